decode_stage: RTL and testbench

Registered, parametrised RV64I+Zba decode stage sitting between fetch and the register-read/execute stage. Decodes every base format (R/I/S/B/U/J), generates the format-correct sign-extended immediate, flags Zba operations and illegal encodings, and buffers the result behind a valid/ready handshake with a 2-entry skid buffer. Back-pressure is absorbed without a combinational ready path, and an explicit flush supports branch redirect.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV64I+Zba decode: combinational field/immediate decode into a registered main+skid buffer.
// Latency 1; in_ready is a flop, so out_ready never reaches in_ready combinationally.
module decode_stage #(
  parameter int XLEN       = 64,
  parameter bit ENABLE_ZBA = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic [1:0]      out_zba_sh,
  output logic            out_zba_uw,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic [1:0]      zba_sh;
    logic            zba_uw;
    logic            illegal;
  } bundle_t;

  bundle_t    dec_d, main_q, skid_q;
  state_e     state_q;
  logic       in_ready_q, out_valid_q;
  logic       push, pop;

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic        legal, base_rr, zba_sh_enc, zba_add_uw, slli_uw;
  fmt_e        fmt;
  logic [63:0] imm64;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // sub/sra are the only funct7=0100000 ops; Zba encodings are gated by the parameter here.
  assign base_rr    = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign zba_sh_enc = ENABLE_ZBA && (f7 == 7'b0010000) && (f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110);
  assign zba_add_uw = ENABLE_ZBA && (f7 == 7'b0000100) && (f3 == 3'b000);
  assign slli_uw    = (f3 == 3'b001) && (in_instr[31:26] == 6'b000010);

  always_comb begin
    legal = 1'b0;
    fmt   = FMT_NONE;
    case (op)
      OP_LUI, OP_AUIPC: begin legal = 1'b1; fmt = FMT_U; end
      OP_JAL:    begin legal = 1'b1; fmt = FMT_J; end
      OP_JALR:   begin legal = (f3 == 3'b000); fmt = FMT_I; end
      OP_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); fmt = FMT_B; end
      OP_LOAD:   begin legal = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110)); fmt = FMT_I; end
      OP_STORE:  begin legal = (f3 <= 3'b010) || (f3 == 3'b011 && RV64); fmt = FMT_S; end
      OP_IMM:    begin legal = 1'b1; fmt = FMT_I; end
      OP_IMM32:  begin legal = RV64 && (!slli_uw || ENABLE_ZBA); fmt = FMT_I; end
      OP_OP:     begin legal = base_rr || zba_sh_enc; fmt = FMT_R; end
      OP_OP32:   begin legal = RV64 && (base_rr || zba_sh_enc || zba_add_uw); fmt = FMT_R; end
      default:   begin legal = 1'b0; fmt = FMT_NONE; end
    endcase
    if (!legal || in_instr[1:0] != 2'b11) fmt = FMT_NONE;

    imm64 = '0;
    case (fmt)
      FMT_I:   imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
      FMT_J:   imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm64 = '0;
    endcase

    dec_d           = '0;
    dec_d.pc        = in_pc;
    dec_d.instr     = in_instr;
    dec_d.imm       = imm64[XLEN-1:0];
    dec_d.fmt       = fmt;
    dec_d.illegal   = (fmt == FMT_NONE);
    dec_d.uses_rs1  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    dec_d.uses_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    dec_d.writes_rd = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                      && (in_instr[11:7] != 5'd0);
    dec_d.zba_sh    = (fmt == FMT_R && zba_sh_enc) ? f3[2:1] : 2'd0;
    dec_d.zba_uw    = (fmt == FMT_R && op == OP_OP32 && (zba_sh_enc || zba_add_uw))
                      || (fmt == FMT_I && op == OP_IMM32 && slli_uw && ENABLE_ZBA);
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: if (push) begin
          main_q      <= dec_d;
          out_valid_q <= 1'b1;
          state_q     <= S_ONE;
        end
        S_ONE: begin
          if (push && pop) begin
            main_q <= dec_d;
          end else if (push) begin
            skid_q     <= dec_d;
            in_ready_q <= 1'b0;
            state_q    <= S_FULL;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= S_EMPTY;
          end
        end
        S_FULL: if (pop) begin
          main_q     <= skid_q;
          in_ready_q <= 1'b1;
          state_q    <= S_ONE;
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = main_q.pc;
  assign out_opcode    = main_q.instr[6:0];
  assign out_rd        = main_q.instr[11:7];
  assign out_funct3    = main_q.instr[14:12];
  assign out_rs1       = main_q.instr[19:15];
  assign out_rs2       = main_q.instr[24:20];
  assign out_funct7    = main_q.instr[31:25];
  assign out_imm       = main_q.imm;
  assign out_fmt       = main_q.fmt;
  assign out_uses_rs1  = main_q.uses_rs1;
  assign out_uses_rs2  = main_q.uses_rs2;
  assign out_writes_rd = main_q.writes_rd;
  assign out_zba_sh    = main_q.zba_sh;
  assign out_zba_uw    = main_q.zba_uw;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases, then random traffic against a queue-based reference model.
module tb_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  // a_: XLEN=64 with Zba, n_: XLEN=64 without Zba, w_: XLEN=32 with Zba
  logic        a_in_ready, a_out_valid, a_u1, a_u2, a_wr, a_uw, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [6:0]  a_op, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3, a_fmt;
  logic [1:0]  a_sh;

  logic        n_in_ready, n_out_valid, n_u1, n_u2, n_wr, n_uw, n_ill;
  logic [63:0] n_pc, n_imm;
  logic [6:0]  n_op, n_f7;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic [2:0]  n_f3, n_fmt;
  logic [1:0]  n_sh;

  logic        w_in_ready, w_out_valid, w_u1, w_u2, w_wr, w_uw, w_ill;
  logic [31:0] w_pc, w_imm;
  logic [6:0]  w_op, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3, w_fmt;
  logic [1:0]  w_sh;

  decode_stage #(.XLEN(64), .ENABLE_ZBA(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_uses_rs1(a_u1), .out_uses_rs2(a_u2), .out_writes_rd(a_wr),
    .out_zba_sh(a_sh), .out_zba_uw(a_uw), .out_illegal(a_ill));

  decode_stage #(.XLEN(64), .ENABLE_ZBA(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_pc), .out_opcode(n_op), .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2),
    .out_funct3(n_f3), .out_funct7(n_f7), .out_imm(n_imm), .out_fmt(n_fmt),
    .out_uses_rs1(n_u1), .out_uses_rs2(n_u2), .out_writes_rd(n_wr),
    .out_zba_sh(n_sh), .out_zba_uw(n_uw), .out_illegal(n_ill));

  decode_stage #(.XLEN(32), .ENABLE_ZBA(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_pc), .out_opcode(w_op), .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_funct3(w_f3), .out_funct7(w_f7), .out_imm(w_imm), .out_fmt(w_fmt),
    .out_uses_rs1(w_u1), .out_uses_rs2(w_u2), .out_writes_rd(w_wr),
    .out_zba_sh(w_sh), .out_zba_uw(w_uw), .out_illegal(w_ill));

  logic [169:0] obs_a, obs_n, obs_w;
  assign obs_a = {a_pc, a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, a_fmt, a_u1, a_u2, a_wr, a_sh, a_uw, a_ill};
  assign obs_n = {n_pc, n_op, n_rd, n_rs1, n_rs2, n_f3, n_f7, n_imm, n_fmt, n_u1, n_u2, n_wr, n_sh, n_uw, n_ill};
  assign obs_w = {32'b0, w_pc, w_op, w_rd, w_rs1, w_rs2, w_f3, w_f7, 32'b0, w_imm, w_fmt,
                  w_u1, w_u2, w_wr, w_sh, w_uw, w_ill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [169:0] obs, input logic [169:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference decode written from the ISA tables; fmt codes R0 I1 S2 B3 U4 J5 NONE7.
  function automatic logic [169:0] ref_bundle(input logic [31:0] i, input logic [63:0] pc,
                                              input int xlen, input bit zba);
    int     f3, f7, fmt, sh;
    bit     ok, uw, base, shadd, adduw, slli, u1, u2, wr;
    longint imm;
    logic [63:0] immv, pcv;
    f3    = int'(i[14:12]);
    f7    = int'(i[31:25]);
    fmt   = 7; sh = 0; ok = 1'b0; uw = 1'b0;
    base  = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
    shadd = zba && f7 == 16 && (f3 == 2 || f3 == 4 || f3 == 6);
    adduw = zba && f7 == 4 && f3 == 0;
    slli  = (f3 == 1) && (i[31:26] == 6'b000010);
    case (i[6:0])
      7'h37, 7'h17: begin fmt = 4; ok = 1'b1; end
      7'h6F: begin fmt = 5; ok = 1'b1; end
      7'h67: begin fmt = 1; ok = (f3 == 0); end
      7'h63: begin fmt = 3; ok = !(f3 inside {2, 3}); end
      7'h03: begin fmt = 1; ok = (f3 != 7) && (xlen == 64 || !(f3 inside {3, 6})); end
      7'h23: begin fmt = 2; ok = (f3 <= 2) || (f3 == 3 && xlen == 64); end
      7'h13: begin fmt = 1; ok = 1'b1; end
      7'h1B: begin fmt = 1; ok = (xlen == 64) && (!slli || zba); uw = slli && zba; end
      7'h33: begin fmt = 0; ok = base || shadd; if (shadd) sh = f3 / 2; end
      7'h3B: begin
        fmt = 0; ok = (xlen == 64) && (base || shadd || adduw);
        uw = shadd || adduw; if (shadd) sh = f3 / 2;
      end
      default: ok = 1'b0;
    endcase
    if (i[1:0] != 2'b11) ok = 1'b0;
    if (!ok) begin fmt = 7; sh = 0; uw = 1'b0; end
    case (fmt)
      1: imm = longint'($signed(i[31:20]));
      2: imm = longint'($signed({i[31:25], i[11:7]}));
      3: imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      4: imm = longint'($signed(i & 32'hFFFF_F000));
      5: imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: imm = 0;
    endcase
    u1   = fmt inside {0, 1, 2, 3};
    u2   = fmt inside {0, 2, 3};
    wr   = (fmt inside {0, 1, 4, 5}) && (i[11:7] != 5'd0);
    immv = (xlen == 32) ? {32'b0, imm[31:0]} : imm;
    pcv  = (xlen == 32) ? {32'b0, pc[31:0]} : pc;
    return {pcv, i[6:0], i[11:7], i[19:15], i[24:20], i[14:12], i[31:25], immv,
            3'(fmt), u1, u2, wr, 2'(sh), uw, !ok};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int sel, k;
    r   = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;  3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h33;  9: r[6:0] = 7'h1B; 10: r[6:0] = 7'h3B; 11: r = 32'h0;
      default: ;
    endcase
    k = $urandom_range(0, 5);
    if (k == 0 && sel != 11) r[31:25] = 7'b0000000;
    if (k == 1) r[31:25] = 7'b0100000;
    if (k == 2) r[31:25] = 7'b0010000;
    if (k == 3) r[31:25] = 7'b0000100;
    if (k == 4) r[31:26] = 6'b000010;
    return r;
  endfunction

  task automatic xfer(input logic [31:0] instr, input logic [63:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  logic [95:0] q[$];
  logic        push, pop;
  localparam logic [31:0] IA = 32'h0010_0093, IB = 32'h0020_0113, IC = 32'h0030_0193;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    chk("reset.a_out_valid", 170'(a_out_valid), 170'(0));
    chk("reset.a_in_ready",  170'(a_in_ready),  170'(1));
    chk("reset.a_outputs",   obs_a, '0);
    chk("reset.n_outputs",   obs_n, '0);
    chk("reset.w_outputs",   obs_w, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x2,-1
    xfer(32'hFFF1_0093, 64'h1000);
    chk("addi.out_valid", 170'(a_out_valid), 170'(1));
    chk("addi.rd",        170'(a_rd),  170'(1));
    chk("addi.rs1",       170'(a_rs1), 170'(2));
    chk("addi.fmt",       170'(a_fmt), 170'(1));
    chk("addi.imm",       170'(a_imm), 170'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("addi.writes_rd", 170'(a_wr),  170'(1));
    chk("addi.pc",        170'(a_pc),  170'(64'h1000));

    // sw x5,-4(x10)
    xfer(32'hFE55_2E23, 64'h1004);
    chk("sw.fmt",       170'(a_fmt), 170'(2));
    chk("sw.rs1",       170'(a_rs1), 170'(10));
    chk("sw.rs2",       170'(a_rs2), 170'(5));
    chk("sw.imm",       170'(a_imm), 170'(64'hFFFF_FFFF_FFFF_FFFC));
    chk("sw.writes_rd", 170'(a_wr),  170'(0));
    chk("sw.uses_rs2",  170'(a_u2),  170'(1));

    // sh2add x3,x4,x5, with and without Zba
    xfer(32'h2052_41B3, 64'h1008);
    chk("sh2add.zba_sh",     170'(a_sh),  170'(2));
    chk("sh2add.zba_uw",     170'(a_uw),  170'(0));
    chk("sh2add.illegal",    170'(a_ill), 170'(0));
    chk("sh2add_nz.illegal", 170'(n_ill), 170'(1));
    chk("sh2add_nz.fmt",     170'(n_fmt), 170'(7));
    chk("sh2add_nz.wr",      170'(n_wr),  170'(0));

    // lui x7,0x80000, then the all-zero word
    xfer(32'h8000_03B7, 64'h100C);
    chk("lui.fmt", 170'(a_fmt), 170'(4));
    chk("lui.imm", 170'(a_imm), 170'(64'hFFFF_FFFF_8000_0000));
    chk("lui.rd",  170'(a_rd),  170'(7));
    xfer(32'h0000_0000, 64'h1010);
    chk("zero.illegal",  170'(a_ill), 170'(1));
    chk("zero.fmt",      170'(a_fmt), 170'(7));
    chk("zero.uses_rs1", 170'(a_u1),  170'(0));

    // ld is RV64-only
    xfer(32'h0001_3083, 64'h1014);
    chk("ld64.illegal", 170'(a_ill), 170'(0));
    chk("ld32.illegal", 170'(w_ill), 170'(1));
    @(negedge clk);
    chk("drain.out_valid", 170'(a_out_valid), 170'(0));

    // Back-pressure: A,B fill the buffer, C is held off until the stall clears
    out_ready = 1'b0; in_valid = 1'b1; in_instr = IA; in_pc = 64'h100;
    @(negedge clk);
    chk("bp.A_in_ready", 170'(a_in_ready), 170'(1));
    chk("bp.A_bundle",   obs_a, ref_bundle(IA, 64'h100, 64, 1'b1));
    in_instr = IB; in_pc = 64'h104;
    @(negedge clk);
    chk("bp.B_in_ready", 170'(a_in_ready), 170'(0));
    in_instr = IC; in_pc = 64'h108;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp.stall_in_ready", 170'(a_in_ready), 170'(0));
      chk("bp.stall_hold_A",   obs_a, ref_bundle(IA, 64'h100, 64, 1'b1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.B_out",      obs_a, ref_bundle(IB, 64'h104, 64, 1'b1));
    chk("bp.B_in_ready", 170'(a_in_ready), 170'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.C_out",   obs_a, ref_bundle(IC, 64'h108, 64, 1'b1));
    chk("bp.C_valid", 170'(a_out_valid), 170'(1));
    @(negedge clk);
    chk("bp.empty_valid", 170'(a_out_valid), 170'(0));

    // Flush while FULL, with a same-cycle input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = IA; in_pc = 64'h200;
    @(negedge clk);
    in_instr = IB; in_pc = 64'h204;
    @(negedge clk);
    chk("fl.full", 170'(a_in_ready), 170'(0));
    flush = 1'b1; in_instr = IC; in_pc = 64'h208;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl.out_valid", 170'(a_out_valid), 170'(0));
    chk("fl.in_ready",  170'(a_in_ready),  170'(1));
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("fl.nothing_emerges", 170'(a_out_valid), 170'(0));
    end

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_instr = IA; in_pc = 64'h300;
    @(negedge clk);
    in_instr = IB; in_pc = 64'h304;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 170'(a_out_valid), 170'(0));
    chk("rst.in_ready",  170'(a_in_ready),  170'(1));
    chk("rst.outputs",   obs_a, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst.after_valid", 170'(a_out_valid), 170'(0));

    // Random traffic against the queue model
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd.a_in_ready",  170'(a_in_ready),  170'(q.size() < 2));
      chk("rnd.a_out_valid", 170'(a_out_valid), 170'(q.size() > 0));
      chk("rnd.n_out_valid", 170'(n_out_valid), 170'(q.size() > 0));
      chk("rnd.w_in_ready",  170'(w_in_ready),  170'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd.a_bundle", obs_a, ref_bundle(q[0][95:64], q[0][63:0], 64, 1'b1));
        chk("rnd.n_bundle", obs_n, ref_bundle(q[0][95:64], q[0][63:0], 64, 1'b0));
        chk("rnd.w_bundle", obs_w, ref_bundle(q[0][95:64], q[0][63:0], 32, 1'b1));
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rnd_instr();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      push      = in_valid && (q.size() < 2);
      pop       = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({in_instr, in_pc});
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
